// File: rtl/music_pkg.sv
// Shared definitions for the music player user-control front end:
// FSM state encoding and the default debounce interval.
package music_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;

   localparam int DEB_CYCLES_DEF = 1_000_000;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_START = ST_START,
      S_RUN   = ST_RUN
   } state_t;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces one raw active-low key; emits a single-cycle
// pulse when the accepted level goes from released to pressed.
module key_debounce
   import music_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic key_level,
   output logic press_pulse
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          sync_q1;
   logic          sync_q2;
   logic [CW-1:0] cnt;
   logic          settle;

   // Accept the new level on the last cycle of an uninterrupted disagreement run
   assign settle = (sync_q2 != key_level) && (cnt == CW'(DEB_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1     <= 1'b1;
         sync_q2     <= 1'b1;
         key_level   <= 1'b1;
         cnt         <= '0;
         press_pulse <= 1'b0;
      end else begin
         sync_q1     <= key_n;
         sync_q2     <= sync_q1;
         press_pulse <= settle & ~sync_q2;
         if (sync_q2 == key_level) begin
            cnt <= '0;
         end else if (settle) begin
            key_level <= sync_q2;
            cnt       <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/music_ctrl.sv
// User-control front end for the buzzer music player: debounced play/pause
// keys, start/pause handshake with the player, auto-repeat and play counter.
module music_ctrl
   import music_pkg::*;
#(
   parameter int CLK_FRE    = 50_000_000,
   parameter int DEB_CYCLES = CLK_FRE / 50,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_play_n,
   input  logic             key_pause_n,
   input  logic             loop_mode,
   input  logic             play_done,
   output logic             play_en,
   output logic             start_stop,
   output logic             busy,
   output logic             paused,
   output logic [CNT_W-1:0] play_count
);

   state_t state;
   state_t state_nxt;
   logic   play_evt;
   logic   pause_evt;
   logic   unused_play_level;
   logic   unused_pause_level;

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_play_key (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_n       (key_play_n),
      .key_level   (unused_play_level),
      .press_pulse (play_evt)
   );

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_pause_key (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_n       (key_pause_n),
      .key_level   (unused_pause_level),
      .press_pulse (pause_evt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (play_evt) state_nxt = S_START;
         S_START: state_nxt = S_RUN;
         S_RUN:   if (play_done) state_nxt = loop_mode ? S_START : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Song end wins over a coincident pause so the player never restarts frozen
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_stop <= 1'b1;
         play_count <= '0;
      end else if (state == S_RUN && play_done) begin
         start_stop <= 1'b1;
         if (play_count != '1) play_count <= play_count + CNT_W'(1);
      end else if (state == S_RUN && pause_evt) begin
         start_stop <= ~start_stop;
      end else if (state != S_RUN) begin
         start_stop <= 1'b1;
      end
   end

   assign play_en = (state == S_START);
   assign busy    = (state != S_IDLE);
   assign paused  = busy & ~start_stop;

endmodule
